// File: rtl/op_pkg.sv
// op_pkg: shared widths, field offsets and result packing for the operator capture stage.
package op_pkg;
    localparam int RES_W  = 19;
    localparam int A_W    = 4;
    localparam int Y4_W   = 8;
    localparam int Y5_W   = 5;
    localparam int Y1_LSB = 0;
    localparam int Y2_LSB = 1;
    localparam int Y3_LSB = 2;
    localparam int Y4_LSB = 6;
    localparam int Y5_LSB = 14;

    function automatic logic [RES_W-1:0] pack_result(
        input logic            y1,
        input logic            y2,
        input logic [A_W-1:0]  y3,
        input logic [Y4_W-1:0] y4,
        input logic [Y5_W-1:0] y5
    );
        logic [RES_W-1:0] w;
        w                  = '0;
        w[Y1_LSB]          = y1;
        w[Y2_LSB]          = y2;
        w[Y3_LSB +: A_W]   = y3;
        w[Y4_LSB +: Y4_W]  = y4;
        w[Y5_LSB +: Y5_W]  = y5;
        return w;
    endfunction
endpackage

// File: rtl/op_fifo.sv
// op_fifo: show-ahead synchronous FIFO; head word is visible on o_rd_data whenever o_rd_valid.
module op_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_fill
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;
    logic             w_push;
    logic             w_pop;

    assign o_wr_ready = r_fill != FULL;
    assign o_rd_valid = r_fill != '0;
    assign w_push     = i_wr_valid && o_wr_ready;
    assign w_pop      = i_rd_ready && o_rd_valid;
    assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign o_fill     = r_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push != w_pop) r_fill <= w_push ? r_fill + 1'b1 : r_fill - 1'b1;
        end
    end
endmodule

// File: rtl/op_result_capture.sv
// op_result_capture: packs y1..y5 into a FIFO and keeps saturating capture statistics
// plus a sticky check that y4 is a true {a,a} replication.
module op_result_capture
    import op_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cap_valid,
    output logic                     cap_ready,
    input  logic                     y1,
    input  logic                     y2,
    input  logic [A_W-1:0]           y3,
    input  logic [Y4_W-1:0]          y4,
    input  logic [Y5_W-1:0]          y5,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [RES_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [CNT_W-1:0]         cap_count,
    output logic [CNT_W-1:0]         le_count,
    output logic                     rep_err,
    input  logic                     clr
);
    logic [RES_W-1:0] w_word;
    logic             w_push;
    logic             w_mis;
    logic [CNT_W-1:0] w_cap_base;
    logic [CNT_W-1:0] w_le_base;
    logic [CNT_W-1:0] r_cap;
    logic [CNT_W-1:0] r_le;
    logic             r_rep;

    assign w_word     = pack_result(y1, y2, y3, y4, y5);
    assign w_push     = cap_valid && cap_ready;
    assign w_mis      = y4[Y4_W-1:A_W] != y4[A_W-1:0];
    // clr and a coincident push merge: the push counts on top of the cleared value
    assign w_cap_base = clr ? '0 : r_cap;
    assign w_le_base  = clr ? '0 : r_le;

    op_fifo #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_valid (cap_valid),
        .o_wr_ready (cap_ready),
        .i_wr_data  (w_word),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_rd_data  (rd_data),
        .o_fill     (fill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap <= '0;
            r_le  <= '0;
            r_rep <= 1'b0;
        end else begin
            r_cap <= w_cap_base + CNT_W'(w_push && !(&w_cap_base));
            r_le  <= w_le_base + CNT_W'(w_push && y1 && !(&w_le_base));
            r_rep <= (r_rep && !clr) || (w_push && w_mis);
        end
    end

    assign cap_count = r_cap;
    assign le_count  = r_le;
    assign rep_err   = r_rep;
endmodule

// File: tb/tb_op_result_capture.sv
// tb_op_result_capture: directed stimulus against a queue-based model, checked every cycle,
// plus hand-computed literal checks; a CNT_W=2 instance covers counter saturation.
module tb_op_result_capture;
    localparam int DEPTH = 4;

    logic        clk = 0, rst_n = 0, cap_valid = 0, rd_ready = 0, clr = 0, y1 = 0, y2 = 0;
    logic [3:0]  y3 = 0;
    logic [7:0]  y4 = 0;
    logic [4:0]  y5 = 0;
    logic        cap_ready, rd_valid, rep_err, s_cap_ready, s_rd_valid, s_rep_err;
    logic [18:0] rd_data, s_rd_data;
    logic [2:0]  fill, s_fill;
    logic [7:0]  cap_count, le_count;
    logic [1:0]  s_cap_count, s_le_count;
    int          passed = 0, total = 0;

    logic [18:0] m_q[$];
    int          m_cnt = 0, m_le = 0;
    bit          m_rep = 0;

    always #5 clk = ~clk;

    op_result_capture #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_ready(cap_ready),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .fill(fill),
        .cap_count(cap_count), .le_count(le_count), .rep_err(rep_err), .clr(clr)
    );

    op_result_capture #(.DEPTH(DEPTH), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_ready(s_cap_ready),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
        .rd_valid(s_rd_valid), .rd_ready(rd_ready), .rd_data(s_rd_data), .fill(s_fill),
        .cap_count(s_cap_count), .le_count(s_le_count), .rep_err(s_rep_err), .clr(clr)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    endtask

    function automatic int sat(input int v, input int mx);
        return v > mx ? mx : v;
    endfunction

    // model: a FIFO is a queue, counters are plain integers clipped on output
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_cnt = 0;
            m_le  = 0;
            m_rep = 0;
        end else begin
            bit push, pop;
            push = cap_valid && (m_q.size() < DEPTH);
            pop  = rd_ready && (m_q.size() > 0);
            if (clr) begin
                m_cnt = 0;
                m_le  = 0;
                m_rep = 0;
            end
            if (push) begin
                m_cnt++;
                if (y1) m_le++;
                if (y4[7:4] != y4[3:0]) m_rep = 1;
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back({y5, y4, y3, y2, y1});
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [18:0] head;
            head = (m_q.size() > 0) ? m_q[0] : 19'd0;
            chk("rd_valid", rd_valid, m_q.size() > 0);
            chk("rd_data", rd_data, head);
            chk("fill", fill, m_q.size());
            chk("cap_ready", cap_ready, m_q.size() < DEPTH);
            chk("cap_count", cap_count, sat(m_cnt, 255));
            chk("le_count", le_count, sat(m_le, 255));
            chk("rep_err", rep_err, m_rep);
            chk("sat_rd_data", s_rd_data, head);
            chk("sat_fill", s_fill, m_q.size());
            chk("sat_cap_count", s_cap_count, sat(m_cnt, 3));
            chk("sat_le_count", s_le_count, sat(m_le, 3));
            chk("sat_rep_err", s_rep_err, m_rep);
        end
    end

    task automatic cyc(input logic cv, input logic rr, input logic cl, input logic [18:0] v);
        cap_valid = cv;
        rd_ready  = rr;
        clr       = cl;
        {y5, y4, y3, y2, y1} = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("lit_reset_cap_ready", cap_ready, 1);
        chk("lit_reset_rd_valid", rd_valid, 0);
        chk("lit_reset_rd_data", rd_data, 0);
        chk("lit_reset_fill", fill, 0);
        chk("lit_reset_cap_count", cap_count, 0);

        cyc(1, 1, 0, 19'b10100_10101010_1111_1_1);
        chk("lit_single_rd_valid", rd_valid, 1);
        chk("lit_single_rd_data", rd_data, 19'b10100_10101010_1111_1_1);
        chk("lit_single_cap_count", cap_count, 1);
        chk("lit_single_le_count", le_count, 1);
        chk("lit_single_rep_err", rep_err, 0);
        cyc(0, 1, 0, 0);

        cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, {5'(i + 3), 8'h11 * 8'(i), 4'(i), 1'b1, 1'(i)});
        chk("lit_full_fill", fill, 4);
        chk("lit_full_cap_ready", cap_ready, 0);
        chk("lit_full_cap_count", cap_count, 4);
        chk("lit_full_head", rd_data, {5'd3, 8'h00, 4'd0, 1'b1, 1'b0});
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        chk("lit_drained_fill", fill, 0);
        cyc(1, 0, 0, 19'h1_2345);
        cyc(1, 0, 0, 19'h5_4321);
        chk("lit_wrap_head", rd_data, 19'h1_2345);

        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 19'h0_1000 + 19'(i));
        chk("lit_simul_fill", fill, 2);
        chk("lit_simul_head", rd_data, 19'h0_1001);
        cyc(1, 0, 0, 19'h2_AAAA);
        cyc(1, 0, 0, 19'h3_5555);
        chk("lit_full2_fill", fill, 4);
        cyc(1, 1, 0, 19'h7_FFFF);
        chk("lit_full_pop_fill", fill, 3);
        chk("lit_full_pop_cap_ready", cap_ready, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);

        cyc(1, 0, 0, {5'd0, 8'b10100101, 4'd0, 1'b0, 1'b0});
        chk("lit_rep_err_set", rep_err, 1);
        cyc(0, 0, 1, 0);
        chk("lit_clr_rep_err", rep_err, 0);
        chk("lit_clr_cap_count", cap_count, 0);
        chk("lit_clr_fill", fill, 1);
        cyc(1, 0, 1, {5'd1, 8'h33, 4'd2, 1'b0, 1'b1});
        chk("lit_clr_push_cap", cap_count, 1);
        chk("lit_clr_push_le", le_count, 1);
        chk("lit_clr_push_rep", rep_err, 0);

        cyc(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, {5'(i), 8'h66, 4'(i), 1'b0, 1'b1});
        chk("lit_sat_cap", s_cap_count, 3);
        chk("lit_sat_le", s_le_count, 3);
        chk("lit_nosat_cap", cap_count, 5);

        cyc(1, 0, 0, 19'h0_0ABC);
        cyc(1, 0, 0, 19'h0_0DEF);
        chk("lit_pre_reset_fill", fill, 3);
        cap_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("lit_async_fill", fill, 0);
        chk("lit_async_rd_valid", rd_valid, 0);
        chk("lit_async_cap_ready", cap_ready, 1);
        chk("lit_async_rd_data", rd_data, 0);
        chk("lit_async_cap_count", cap_count, 0);
        @(negedge clk);
        #1 rst_n = 1;
        cyc(1, 0, 0, 19'h4_0001);
        chk("lit_recover_rd_data", rd_data, 19'h4_0001);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/op_result_capture.md
Name: op_result_capture

Overview:
- Downstream stage of the 4-bit operator block; consumes its five result buses y1..y5.
- Packs each sampled result set into one 19-bit word and buffers it in a small show-ahead FIFO behind a valid/ready read port.
- Keeps saturating statistics: number of captures, number of captures with y1=1 (a<=b).
- Runs a sticky replication-consistency check on y4.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >=2
- CNT_W, 8, width of the statistics counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cap_valid  in  1  result set on y1..y5 is valid this cycle
- cap_ready  out  1  block can accept a capture (FIFO not full)
- y1  in  1  compare result (a<=b)
- y2  in  1  logical-AND result
- y3  in  4  bitwise-OR result
- y4  in  8  replication result {a,a}
- y5  in  5  concatenation result {a,c}
- rd_valid  out  1  FIFO head word available
- rd_ready  in  1  consumer takes head word
- rd_data  out  19  head word, packed {y5,y4,y3,y2,y1}
- fill  out  $clog2(DEPTH)+1  current occupancy
- cap_count  out  CNT_W  accepted captures, saturating
- le_count  out  CNT_W  accepted captures with y1=1, saturating
- rep_err  out  1  sticky: a capture had y4[7:4]!=y4[3:0]
- clr  in  1  synchronous clear of cap_count, le_count, rep_err

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except cap_ready=1. FIFO pointers and storage are 0.
- Packing: bit0=y1, bit1=y2, bits5:2=y3, bits13:6=y4, bits18:14=y5.
- Push:
  - A push occurs on a clk edge with cap_valid && cap_ready.
  - cap_ready = (fill != DEPTH), combinational from state only.
- Pop:
  - A pop occurs on a clk edge with rd_valid && rd_ready.
  - rd_valid = (fill != 0).
- Show-ahead read:
  - rd_data = storage[rd_ptr] while rd_valid=1; forced to 0 when empty.
  - Latency: a word pushed at edge N appears on rd_data after edge N if the FIFO was empty.
- Simultaneous push and pop:
  - When not full and not empty, both occur and fill is unchanged.
  - When full, cap_ready=0, so only the pop occurs and cap_ready rises next cycle. No same-cycle bypass into a full FIFO.
  - When empty, only the push occurs; rd_ready is ignored.
- Pop on empty and push while full are ignored: no pointer or fill change, no error.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. fill is a separate counter, 0..DEPTH.
- Statistics:
  - On each push, cap_count increments, saturating at 2^CNT_W-1.
  - le_count increments on a push with y1=1, with the same saturation.
- rep_err: set on a push with y4[7:4]!=y4[3:0]. It stays set until clr or reset.
- clr:
  - Clears cap_count, le_count and rep_err; does not touch FIFO contents or pointers.
  - If clr and a push coincide, counters load the push contribution (0 or 1) rather than 0. rep_err loads the mismatch result of that push. No event is lost.
- Reset mid-operation: asynchronous assertion immediately empties the FIFO and zeroes every output as above. Deassertion is synchronized by the system; the block needs no internal synchronizer.
- All sampled inputs are registered on clk only; no combinational path from y1..y5 to any output.

Decomposition:
- Package op_pkg holds:
  - widths: RES_W=19, A_W=4, Y4_W=8, Y5_W=5
  - field offset constants Y1_LSB..Y5_LSB
  - function pack_result(y1,y2,y3,y4,y5) returning the 19-bit word
- Sub-module op_fifo: generic show-ahead synchronous FIFO with parameters WIDTH and DEPTH. It owns pointers, fill and storage.
- op_result_capture instantiates op_fifo and implements packing, statistics, rep_err and clr.

Test Plan:
- Reset and empty behaviour:
  - Hold rst_n=0, then release; drive rd_ready=1 and 2 cycles with cap_valid=0.
  - Expect cap_ready=1, rd_valid=0, rd_data=0, fill=0, all counters 0.
- Single capture:
  - Push y1=1,y2=1,y3=4'b1111,y4=8'b10101010,y5=5'b10100.
  - Next cycle expect rd_valid=1 and rd_data=19'b10100_10101010_1111_1_1.
  - Also cap_count=1, le_count=1, rep_err=0.
- Full and wrap:
  - Push 5 words with rd_ready=0. Expect cap_ready=0 after 4, 5th dropped, fill=4, cap_count=4.
  - Pop all 4, then push 2 more. Expect FIFO order preserved across the pointer wrap.
- Simultaneous push and pop:
  - At fill=2, assert cap_valid and rd_ready together for 3 cycles. Expect fill stays 2 and words exit in push order.
  - At fill=4, assert both. Expect only the pop, with fill=3.
- rep_err and clr:
  - Push y4=8'b10100101. Expect rep_err=1 next cycle.
  - Assert clr alone: rep_err=0, counters 0, FIFO unchanged.
  - Assert clr together with a push of y1=1: cap_count=1, le_count=1.
- Saturation and async reset:
  - With CNT_W=2, push 5 words with y1=1 while popping continuously. Expect cap_count=le_count=3.
  - Drop rst_n mid-stream at fill=3. Expect fill=0, rd_valid=0, cap_ready=1 immediately, before the next clk edge.
